// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus register bank / transfer sequencer.
package bus_pkg;
  localparam int BUS_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_DRIVE = 2'd1;
  localparam state_t S_LATCH = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Out-of-range indices decode to all-zero, so callers get "ignore" for free.
  function automatic logic [15:0] onehot16(input logic [31:0] idx);
    return (idx < 32'd16) ? (16'h1 << idx[3:0]) : 16'h0;
  endfunction
endpackage

// File: rtl/bus_reg32.sv
// One bus-width register with async active-low clear and load enable.
module bus_reg32 import bus_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [BUS_W-1:0] d,
  output logic [BUS_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/bus_xfer_seq.sv
// Register bank plus reg->bus->reg transfer sequencer feeding tri-state drivers.
module bus_xfer_seq import bus_pkg::*; #(
  parameter int NREGS = 8,
  parameter int SELW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  xfer_valid,
  output logic                  xfer_ready,
  input  logic [SELW-1:0]       src_sel,
  input  logic [SELW-1:0]       dst_sel,
  input  logic                  wr_en,
  input  logic [SELW-1:0]       wr_idx,
  input  logic [BUS_W-1:0]      wr_data,
  input  logic [BUS_W-1:0]      bus_in,
  output logic [NREGS-1:0]      drv_sel,
  output logic [NREGS*32-1:0]   reg_q,
  output logic                  xfer_done,
  output logic                  xfer_err
);
  localparam logic [31:0] NR = NREGS;

  state_t                       state;
  logic [SELW-1:0]              dst_q;
  logic [NREGS-1:0]             src_oh, dst_oh, wr_oh, ld;
  logic [NREGS-1:0][BUS_W-1:0]  q;
  logic [BUS_W-1:0]             d_in;
  logic                         idle, accept, bad;

  assign idle       = (state == S_IDLE);
  assign xfer_ready = idle && !wr_en;
  assign accept     = xfer_valid && xfer_ready;
  assign bad        = (32'(src_sel) >= NR) || (32'(dst_sel) >= NR);
  assign xfer_done  = (state == S_DONE);

  assign src_oh = NREGS'(onehot16(32'(src_sel)));
  assign dst_oh = NREGS'(onehot16(32'(dst_q)));
  assign wr_oh  = NREGS'(onehot16(32'(wr_idx)));

  // drv_sel is loaded once at accept and held through DRIVE+LATCH, so it
  // doubles as the captured source index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      drv_sel  <= '0;
      dst_q    <= '0;
      xfer_err <= 1'b0;
    end else begin
      xfer_err <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (bad) xfer_err <= 1'b1;
          else begin
            state   <= S_DRIVE;
            drv_sel <= src_oh;
            dst_q   <= dst_sel;
          end
        end
        S_DRIVE: state <= S_LATCH;
        S_LATCH: begin
          state   <= S_DONE;
          drv_sel <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only one load source can be live per state, so a single data mux suffices.
  assign d_in = (state == S_LATCH) ? bus_in : wr_data;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign ld[i] = ((state == S_LATCH) && dst_oh[i]) || (idle && wr_en && wr_oh[i]);
    bus_reg32 u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld[i]),
      .d     (d_in),
      .q     (q[i])
    );
  end

  assign reg_q = q;
endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed table, reset corner cases and randomized run against a timeline model.
module tb_bus_xfer_seq;
  localparam int NREGS = 8;
  localparam int SELW  = 4;
  localparam int QW    = NREGS * 32;

  logic              clk, rst_n;
  logic              xfer_valid, xfer_ready, wr_en, xfer_done, xfer_err;
  logic [SELW-1:0]   src_sel, dst_sel, wr_idx;
  logic [31:0]       wr_data, bus_in;
  logic [NREGS-1:0]  drv_sel;
  logic [QW-1:0]     reg_q;

  int ntot = 0, npass = 0;

  bus_xfer_seq #(.NREGS(NREGS), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .src_sel(src_sel), .dst_sel(dst_sel), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .bus_in(bus_in), .drv_sel(drv_sel), .reg_q(reg_q),
    .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: wired-OR of whichever registers are driving.
  always_comb begin
    bus_in = '0;
    for (int i = 0; i < NREGS; i++)
      if (drv_sel[i]) bus_in = bus_in | reg_q[32*i +: 32];
  end

  task automatic chk(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else npass++;
  endtask

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic        vld;
    logic [3:0]  src, dst;
    logic        e_rdy;
    logic [7:0]  e_drv;
    logic        e_done, e_err;
    int          ci;
    logic [31:0] cv;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic we, logic [3:0] wi, logic [31:0] wd, logic v,
                              logic [3:0] s, logic [3:0] d, logic rdy, logic [7:0] drv,
                              logic dn, logic er, int ci, logic [31:0] cv);
    vec_t r;
    r.wr_en = we; r.wr_idx = wi; r.wr_data = wd; r.vld = v; r.src = s; r.dst = d;
    r.e_rdy = rdy; r.e_drv = drv; r.e_done = dn; r.e_err = er; r.ci = ci; r.cv = cv;
    return r;
  endfunction

  task automatic idle_inputs();
    wr_en = 0; wr_idx = 0; wr_data = 0; xfer_valid = 0; src_sel = 0; dst_sel = 0;
  endtask

  // Model state for the random phase: regs plus the edge index of the last accept.
  logic [31:0] mr[NREGS];
  int          acc, e, as_, ad_;

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    chk("rst_drv", QW'(drv_sel), '0);
    chk("rst_regs", reg_q, '0);
    chk("rst_done_err", QW'({xfer_done, xfer_err}), '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    #1 chk("rst_ready", QW'(xfer_ready), QW'(1));

    //            we wi  wdata         v  s  d  rdy drv    dn er  ci cv
    tbl[0]  = mk(1, 1, 32'hDEADBEEF, 1, 1, 5, 0, 8'h00, 0, 0, 1, 32'hDEADBEEF);
    tbl[1]  = mk(0, 0, 32'h0,        1, 1, 5, 1, 8'h02, 0, 0, 5, 32'h0);
    tbl[2]  = mk(1, 1, 32'h0,        0, 0, 0, 0, 8'h02, 0, 0, 5, 32'h0);
    tbl[3]  = mk(1, 5, 32'h11111111, 0, 0, 0, 0, 8'h00, 1, 0, 5, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h00, 0, 0, 1, 32'hDEADBEEF);
    tbl[5]  = mk(0, 0, 32'h0,        1, 9, 2, 1, 8'h00, 0, 1, 2, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,        1, 2, 9, 1, 8'h00, 0, 1, 2, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 0, 1, 8'h00, 0, 0, 2, 32'h0);
    tbl[8]  = mk(1, 2, 32'h12345678, 0, 0, 0, 0, 8'h00, 0, 0, 2, 32'h12345678);
    tbl[9]  = mk(1, 8, 32'hFFFFFFFF, 0, 0, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,        1, 2, 3, 1, 8'h04, 0, 0, 3, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,        1, 3, 4, 0, 8'h04, 0, 0, 3, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,        1, 3, 4, 0, 8'h00, 1, 0, 3, 32'h12345678);
    tbl[13] = mk(0, 0, 32'h0,        1, 3, 4, 0, 8'h00, 0, 0, 4, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,        1, 3, 4, 1, 8'h08, 0, 0, 4, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h08, 0, 0, 4, 32'h0);
    tbl[16] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h00, 1, 0, 4, 32'h12345678);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h00, 0, 0, 3, 32'h12345678);
    tbl[18] = mk(0, 0, 32'h0,        1, 4, 4, 1, 8'h10, 0, 0, 4, 32'h12345678);
    tbl[19] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h10, 0, 0, 4, 32'h12345678);
    tbl[20] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h00, 1, 0, 4, 32'h12345678);
    tbl[21] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8'h00, 0, 0, 5, 32'hDEADBEEF);

    for (int k = 0; k < 22; k++) begin
      wr_en = tbl[k].wr_en; wr_idx = tbl[k].wr_idx; wr_data = tbl[k].wr_data;
      xfer_valid = tbl[k].vld; src_sel = tbl[k].src; dst_sel = tbl[k].dst;
      #1 chk($sformatf("tbl%0d_ready", k), QW'(xfer_ready), QW'(tbl[k].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_drv", k), QW'(drv_sel), QW'(tbl[k].e_drv));
      chk($sformatf("tbl%0d_done", k), QW'(xfer_done), QW'(tbl[k].e_done));
      chk($sformatf("tbl%0d_err", k), QW'(xfer_err), QW'(tbl[k].e_err));
      chk($sformatf("tbl%0d_r%0d", k, tbl[k].ci), QW'(reg_q[32*tbl[k].ci +: 32]), QW'(tbl[k].cv));
    end

    // Reset asserted mid-cycle during LATCH of r0->r7.
    idle_inputs();
    wr_en = 1; wr_idx = 0; wr_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    idle_inputs();
    xfer_valid = 1; src_sel = 0; dst_sel = 7;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("latch_drv_pre", QW'(drv_sel), QW'(8'h01));
    #2 rst_n = 0;
    #1;
    chk("midrst_drv", QW'(drv_sel), '0);
    chk("midrst_regs", reg_q, '0);
    chk("midrst_done", QW'(xfer_done), '0);
    @(posedge clk); #1;
    chk("midrst_hold_regs", reg_q, '0);
    rst_n = 1;
    #1 chk("midrst_ready", QW'(xfer_ready), QW'(1));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst%0d_done", c), QW'({xfer_done, xfer_err}), '0);
      chk($sformatf("postrst%0d_drv", c), QW'(drv_sel), '0);
      chk($sformatf("postrst%0d_r7", c), QW'(reg_q[32*7 +: 32]), '0);
    end

    // Randomized phase: expectations come from edge-index arithmetic on the
    // last accept (drive for 2 edges, write+done at +2, free again at +4).
    for (int i = 0; i < NREGS; i++) mr[i] = '0;
    acc = -100; e = 0; as_ = 0; ad_ = 0;
    for (int n = 0; n < 300; n++) begin
      logic idle, berr;
      logic [7:0] edrv;
      logic [QW-1:0] eq;
      wr_en = ($urandom_range(0, 3) == 0);
      wr_idx = 4'($urandom_range(0, 9));
      wr_data = $urandom;
      xfer_valid = 1'($urandom_range(0, 1));
      src_sel = 4'($urandom_range(0, 9));
      dst_sel = 4'($urandom_range(0, 9));
      idle = (e >= acc + 4);
      #1 chk("rnd_ready", QW'(xfer_ready), QW'(idle && !wr_en));
      @(posedge clk); #1;
      berr = 0;
      if (idle && wr_en) begin
        if (wr_idx < NREGS) mr[wr_idx] = wr_data;
      end else if (idle && xfer_valid) begin
        if (src_sel >= NREGS || dst_sel >= NREGS) berr = 1;
        else begin acc = e; as_ = src_sel; ad_ = dst_sel; end
      end
      if (e == acc + 2) mr[ad_] = mr[as_];
      edrv = (e == acc || e == acc + 1) ? (8'd1 << as_) : 8'd0;
      for (int i = 0; i < NREGS; i++) eq[32*i +: 32] = mr[i];
      chk("rnd_drv", QW'(drv_sel), QW'(edrv));
      chk("rnd_done", QW'(xfer_done), QW'(e == acc + 2));
      chk("rnd_err", QW'(xfer_err), QW'(berr));
      chk("rnd_regs", reg_q, eq);
      e++;
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
